i2c_wb_fifo_bridge: RTL and testbench

//  Wishbone slave register bank with parametrised TX/RX byte FIFOs in front of the i2c byte engine.

---
 rtl/i2c_wb_fifo_bridge_pkg.sv | 44 ++++
 rtl/i2c_sync_fifo.sv | 74 +++++++
 rtl/i2c_wb_fifo_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_wb_fifo_bridge.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_wb_fifo_bridge_pkg.sv
// ---------------------------------------------------------------------------
// i2c_wb_fifo_bridge_pkg
//  Shared definitions for the Wishbone <-> i2c byte-engine FIFO bridge:
//  register offsets, CTRL / STATUS / IRQ_EN bit positions and a helper that
//  classifies read-only registers.
// ---------------------------------------------------------------------------
package i2c_wb_fifo_bridge_pkg;

  // Register offsets (wb_adr_i[2:0])
  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_STATUS  = 3'd1,
    REG_TXDATA  = 3'd2,
    REG_RXDATA  = 3'd3,
    REG_IRQ_EN  = 3'd4,
    REG_RX_THR  = 3'd5,
    REG_LEVEL   = 3'd6,
    REG_IRQ_CLR = 3'd7
  } reg_addr_e;

  // CTRL bits
  localparam int CTRL_CORE_EN  = 0;
  localparam int CTRL_FLUSH_TX = 1;
  localparam int CTRL_FLUSH_RX = 2;

  // STATUS bits (IRQ_CLR reuses the ovf positions)
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVF   = 5;
  localparam int ST_IRQ      = 6;

  // IRQ_EN bits
  localparam int IRQ_RX_THR   = 0;
  localparam int IRQ_TX_EMPTY = 1;
  localparam int IRQ_OVF      = 2;

  function automatic logic is_ro_reg(reg_addr_e a);
    return (a == REG_STATUS) || (a == REG_RXDATA) || (a == REG_LEVEL);
  endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// ---------------------------------------------------------------------------
// i2c_sync_fifo
//  Single-clock byte FIFO with first-word-fall-through head output.
//  A push is accepted when not full, or when a pop happens in the same cycle.
//  Flush empties the FIFO on the next edge and overrides push/pop.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  push/push_data, pop, flush   control
//  head_data    entry at read pointer (undefined when empty)
//  full, empty, count           status
//  ovf          push refused because full (single-cycle, combinational)
// ---------------------------------------------------------------------------
module i2c_sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [DW-1:0]              head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf     = push & ~push_ok & ~flush;

  assign count     = count_q;
  assign head_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count define validity,
  // so resetting the data would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/i2c_wb_fifo_bridge.sv
// ---------------------------------------------------------------------------
// i2c_wb_fifo_bridge
//  Wishbone slave register bank with TX/RX byte FIFOs in front of an i2c byte
//  engine. Sticky overflow flags and a registered, masked interrupt.
//  Optional macro I2C_WB_ERR_EN: illegal accesses (addr>7, write to a
//  read-only register, read of TXDATA) answer with wb_err_o and have no side
//  effects. Without it they are acked, writes ignored, reads return 0.
// Ports:
//  wb_clk_i, wb_rst_i (async, active-low)
//  wb_adr_i/dat_i/dat_o/we_i/stb_i/cyc_i/ack_o/err_o   Wishbone slave
//  irq_o        interrupt to processor
//  core_en_o    engine enable
//  tx_data_o/tx_valid_o/tx_ready_i   TX byte stream to the engine
//  rx_data_i/rx_valid_i              RX byte push from the engine
// Bus timing: ack rises one cycle after stb&cyc; the access takes effect on
// the edge that ends the ack cycle, and wb_dat_o is valid during ack.
// ---------------------------------------------------------------------------
module i2c_wb_fifo_bridge
  import i2c_wb_fifo_bridge_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic [DW-1:0]     wb_dat_o,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              irq_o,
  output logic              core_en_o,
  output logic [DW-1:0]     tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [DW-1:0]     rx_data_i,
  input  logic              rx_valid_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             ack_q, err_q;
  logic             core_en_q, tx_ovf_q, rx_ovf_q, irq_q;
  logic [2:0]       irq_en_q;
  logic [CNT_W-1:0] rx_thr_q;

  logic [DW-1:0]    tx_head, rx_head;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic             tx_ovf_set, rx_ovf_set;

  // ---------------- bus decode ----------------
  reg_addr_e reg_sel;
  logic      adr_hi, req, acc, wr, rd;

  assign reg_sel = reg_addr_e'(wb_adr_i[2:0]);
  assign adr_hi  = |wb_adr_i[ADDR_W-1:3];
  assign req     = wb_stb_i & wb_cyc_i & ~ack_q & ~err_q;
  // Side effects happen at the end of the ack cycle, while the master still
  // holds address and data.
  assign acc     = ack_q & wb_stb_i & wb_cyc_i;
  assign wr      = acc & wb_we_i & ~adr_hi;
  assign rd      = acc & ~wb_we_i & ~adr_hi;

`ifdef I2C_WB_ERR_EN
  logic bad;
  assign bad = adr_hi
             | ( wb_we_i & is_ro_reg(reg_sel))
             | (~wb_we_i & (reg_sel == REG_TXDATA));

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= req & ~bad;
      err_q <= req & bad;
    end
  end
`else
  assign err_q = 1'b0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) ack_q <= 1'b0;
    else           ack_q <= req;
  end
`endif

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

  // ---------------- FIFO control ----------------
  logic wr_ctrl, wr_tx, wr_clr, rd_rx;
  logic tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;

  assign wr_ctrl = wr & (reg_sel == REG_CTRL);
  assign wr_tx   = wr & (reg_sel == REG_TXDATA);
  assign wr_clr  = wr & (reg_sel == REG_IRQ_CLR);
  assign rd_rx   = rd & (reg_sel == REG_RXDATA);

  // A disabled core keeps both FIFOs flushed.
  assign tx_flush = (wr_ctrl & wb_dat_i[CTRL_FLUSH_TX]) | ~core_en_q;
  assign rx_flush = (wr_ctrl & wb_dat_i[CTRL_FLUSH_RX]) | ~core_en_q;
  assign tx_push  = wr_tx & core_en_q;
  assign tx_pop   = tx_valid_o & tx_ready_i;
  assign rx_push  = rx_valid_i & core_en_q;
  assign rx_pop   = rd_rx;

  i2c_sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_i),
    .push      (tx_push),
    .push_data (wb_dat_i),
    .pop       (tx_pop),
    .flush     (tx_flush),
    .head_data (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_cnt),
    .ovf       (tx_ovf_set)
  );

  i2c_sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_i),
    .push      (rx_push),
    .push_data (rx_data_i),
    .pop       (rx_pop),
    .flush     (rx_flush),
    .head_data (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_cnt),
    .ovf       (rx_ovf_set)
  );

  assign core_en_o  = core_en_q;
  assign tx_valid_o = ~tx_empty & core_en_q;
  // Gate the head so the uninitialised storage never reaches the pins.
  assign tx_data_o  = tx_empty ? '0 : tx_head;

  // ---------------- registers ----------------
  logic [2:0] irq_src;

  always_comb begin
    irq_src               = '0;
    irq_src[IRQ_RX_THR]   = (rx_cnt >= rx_thr_q) && (rx_cnt != '0);
    irq_src[IRQ_TX_EMPTY] = tx_empty;
    irq_src[IRQ_OVF]      = tx_ovf_q | rx_ovf_q;
  end

  // NOTE: state registers use non-blocking assignments only; later
  // assignments in the block deliberately override earlier ones.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      core_en_q <= 1'b0;
      irq_en_q  <= '0;
      rx_thr_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_ctrl) core_en_q <= wb_dat_i[CTRL_CORE_EN];
      if (wr && reg_sel == REG_IRQ_EN) irq_en_q <= wb_dat_i[2:0];
      if (wr && reg_sel == REG_RX_THR) rx_thr_q <= wb_dat_i[CNT_W-1:0];
      // Clear first, set last: a same-cycle set wins.
      if (wr_clr && wb_dat_i[ST_TX_OVF]) tx_ovf_q <= 1'b0;
      if (wr_clr && wb_dat_i[ST_RX_OVF]) rx_ovf_q <= 1'b0;
      if (tx_ovf_set) tx_ovf_q <= 1'b1;
      if (rx_ovf_set) rx_ovf_q <= 1'b1;
      irq_q <= |(irq_en_q & irq_src);
    end
  end

  assign irq_o = irq_q;

  // ---------------- read mux ----------------
  logic [DW-1:0] rdata;

  // NOTE: every combinational output gets a default first so no path infers
  // a latch.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:   rdata[CTRL_CORE_EN] = core_en_q;
      REG_STATUS: begin
        rdata[ST_TX_FULL]  = tx_full;
        rdata[ST_TX_EMPTY] = tx_empty;
        rdata[ST_RX_FULL]  = rx_full;
        rdata[ST_RX_EMPTY] = rx_empty;
        rdata[ST_TX_OVF]   = tx_ovf_q;
        rdata[ST_RX_OVF]   = rx_ovf_q;
        rdata[ST_IRQ]      = irq_q;
      end
      REG_RXDATA: rdata = rx_empty ? '0 : rx_head;
      REG_IRQ_EN: rdata[2:0] = irq_en_q;
      REG_RX_THR: rdata[CNT_W-1:0] = rx_thr_q;
      REG_LEVEL:  rdata[7:0] = {4'(tx_cnt), 4'(rx_cnt)};
      default:    rdata = '0;
    endcase
  end

  assign wb_dat_o = (ack_q && !adr_hi) ? rdata : '0;

endmodule

// File: tb/tb_i2c_wb_fifo_bridge.sv
// ---------------------------------------------------------------------------
// tb_i2c_wb_fifo_bridge
//  Directed self-checking bench for i2c_wb_fifo_bridge (default parameters).
//  Honours I2C_WB_ERR_EN for the out-of-range access case.
// ---------------------------------------------------------------------------
module tb_i2c_wb_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wb_adr, wb_dat_i, wb_dat_o, tx_data, rx_data;
  logic       wb_we, wb_stb, wb_cyc, wb_ack, wb_err, irq, core_en;
  logic       tx_valid, tx_ready, rx_valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic       last_err, last_ack;
  logic       ready_pulse;   // raise tx_ready_i only on the access's effect edge
  logic [7:0] rd_val;

  always #5 clk = ~clk;

  i2c_wb_fifo_bridge dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_we_i    (wb_we),
    .wb_stb_i   (wb_stb),
    .wb_cyc_i   (wb_cyc),
    .wb_ack_o   (wb_ack),
    .wb_err_o   (wb_err),
    .irq_o      (irq),
    .core_en_o  (core_en),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One Wishbone classic access; returns read data sampled during ack/err.
  task automatic wb_access(input logic we, input logic [7:0] adr, input logic [7:0] wdat,
                           output logic [7:0] rdat);
    int n = 0;
    wb_adr = adr; wb_dat_i = wdat; wb_we = we; wb_stb = 1'b1; wb_cyc = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!(wb_ack || wb_err) && n < 20);
    if (!(wb_ack || wb_err)) check("wb_response_timeout", {31'd0, wb_ack | wb_err}, 32'd1);
    rdat = wb_dat_o; last_ack = wb_ack; last_err = wb_err;
    if (ready_pulse) tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [7:0] wdat);
    logic [7:0] dummy;
    wb_access(1'b1, adr, wdat, dummy);
  endtask

  task automatic wb_read(input logic [7:0] adr, output logic [7:0] rdat);
    wb_access(1'b0, adr, 8'h00, rdat);
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    wb_adr = '0; wb_dat_i = '0; wb_we = 0; wb_stb = 0; wb_cyc = 0;
    tx_ready = 0; rx_data = '0; rx_valid = 0; ready_pulse = 0;
    rst_n = 1'b0;
    idle(3);
    check("rst_outputs", {wb_ack, wb_err, irq, core_en, tx_valid, tx_data, wb_dat_o},
          32'd0);
    rst_n = 1'b1;
    idle(1);

    wb_read(8'h01, rd_val); check("rst_status", rd_val, 8'h0A);
    wb_read(8'h06, rd_val); check("rst_level",  rd_val, 8'h00);

    // TX path: enable, queue two bytes, drain with tx_ready.
    wb_write(8'h00, 8'h01);
    check("core_en", core_en, 1);
    wb_write(8'h02, 8'hA5);
    check("tx_valid_after_push", tx_valid, 1);
    wb_write(8'h02, 8'h5A);
    wb_read(8'h06, rd_val); check("level_tx2", rd_val, 8'h20);
    check("tx_head_a5", tx_data, 8'hA5);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    check("tx_head_5a", tx_data, 8'h5A);
    check("tx_valid_mid", tx_valid, 1);
    @(posedge clk); #1;
    check("tx_valid_drained", tx_valid, 0);
    tx_ready = 1'b0;

    // RX fill to full plus one overflow, then read back in order.
    for (int i = 0; i < 9; i++) rx_push(8'h10 + 8'(i));
    wb_read(8'h01, rd_val); check("status_rx_full_ovf", rd_val, 8'h26);
    wb_read(8'h06, rd_val); check("level_rx8", rd_val, 8'h08);
    for (int i = 0; i < 8; i++) begin
      wb_read(8'h03, rd_val);
      check($sformatf("rxdata_%0d", i), rd_val, 8'h10 + 8'(i));
    end
    wb_read(8'h03, rd_val); check("rxdata_empty", rd_val, 8'h00);
    wb_read(8'h01, rd_val); check("status_rx_drained", rd_val, 8'h2A);
    wb_write(8'h07, 8'h20);
    wb_read(8'h01, rd_val); check("status_rx_ovf_clr", rd_val, 8'h0A);
    wb_read(8'h07, rd_val); check("irq_clr_reads0", rd_val, 8'h00);

    // RX threshold interrupt.
    wb_write(8'h05, 8'h03);
    wb_read(8'h05, rd_val); check("rx_thr_rb", rd_val, 8'h03);
    wb_write(8'h04, 8'h01);
    rx_push(8'h31); rx_push(8'h32);
    idle(2); check("irq_below_thr", irq, 0);
    rx_push(8'h33);
    idle(2); check("irq_at_thr", irq, 1);
    wb_read(8'h01, rd_val); check("status_irq", rd_val, 8'h42);
    wb_read(8'h03, rd_val); check("rxdata_thr_pop", rd_val, 8'h31);
    idle(2); check("irq_after_pop", irq, 0);
    wb_write(8'h00, 8'h05);
    wb_read(8'h06, rd_val); check("level_after_flush_rx", rd_val, 8'h00);
    wb_read(8'h00, rd_val); check("ctrl_selfclr", rd_val, 8'h01);
    wb_write(8'h04, 8'h00);

    // TX full: push coinciding with a pop is accepted, no overflow.
    for (int i = 0; i < 8; i++) wb_write(8'h02, 8'h80 + 8'(i));
    wb_read(8'h01, rd_val); check("status_tx_full", rd_val, 8'h09);
    ready_pulse = 1'b1;
    wb_write(8'h02, 8'h88);
    ready_pulse = 1'b0;
    wb_read(8'h06, rd_val); check("level_full_pushpop", rd_val, 8'h80);
    check("tx_head_after_pop", tx_data, 8'h81);
    wb_read(8'h01, rd_val); check("status_no_tx_ovf", rd_val, 8'h09);
    wb_write(8'h02, 8'h89);
    wb_read(8'h01, rd_val); check("status_tx_ovf", rd_val, 8'h19);
    wb_write(8'h04, 8'h04);
    idle(2); check("irq_ovf", irq, 1);
    wb_write(8'h07, 8'h10);
    idle(2); check("irq_ovf_cleared", irq, 0);
    wb_read(8'h01, rd_val); check("status_tx_ovf_clr", rd_val, 8'h09);
    wb_write(8'h00, 8'h03);
    wb_read(8'h06, rd_val); check("level_after_flush_tx", rd_val, 8'h00);

    // TX-empty interrupt source.
    wb_write(8'h04, 8'h02);
    idle(2); check("irq_tx_empty", irq, 1);
    wb_write(8'h04, 8'h00);
    idle(2); check("irq_masked", irq, 0);

    // Disabled core drops traffic without overflow.
    wb_write(8'h00, 8'h00);
    rx_push(8'h44);
    wb_write(8'h02, 8'h55);
    check("tx_valid_disabled", tx_valid, 0);
    wb_read(8'h06, rd_val); check("level_disabled", rd_val, 8'h00);
    wb_read(8'h01, rd_val); check("status_disabled", rd_val, 8'h0A);

    // Out-of-range address.
    wb_read(8'h08, rd_val);
`ifdef I2C_WB_ERR_EN
    check("badaddr_err", last_err, 1);
    check("badaddr_noack", last_ack, 0);
`else
    check("badaddr_ack", last_ack, 1);
    check("badaddr_noerr", last_err, 0);
    check("badaddr_data", rd_val, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
